// File: rtl/i2s_receiver_if.sv
// I2S receiver bus: serial line inputs plus the valid/ready frame output.
// The master modport is the receiver; the slave modport is the line source / frame consumer.
interface i2s_receiver_if #(
    parameter int WORD_LENGTH = 16
);
    logic                     serial_data;
    logic                     word_select;
    logic [2*WORD_LENGTH-1:0] data;
    logic                     data_valid;
    logic                     data_ready;
    logic                     overrun;
    logic                     frame_error;

    modport master (
        input  serial_data,
        input  word_select,
        input  data_ready,
        output data,
        output data_valid,
        output overrun,
        output frame_error
    );

    modport slave (
        output serial_data,
        output word_select,
        output data_ready,
        input  data,
        input  data_valid,
        input  overrun,
        input  frame_error
    );
endinterface

// File: rtl/i2s_receiver.sv
// I2S receiver: assembles {left, right} frames, MSB first, one-bit delay after each word_select edge.
// Define I2S_RECEIVER_ERROR_FLAGS_EN to make the sticky overrun / frame_error flags live.
module i2s_receiver #(
    parameter int WORD_LENGTH = 16
) (
    input logic           i_clk,
    input logic           i_rst,
    i2s_receiver_if.master bus
);
    localparam int CW = $clog2(WORD_LENGTH) + 1;
    localparam logic [CW-1:0] LP_FULL = CW'(WORD_LENGTH);
    localparam logic [CW-1:0] LP_LAST = CW'(WORD_LENGTH - 1);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_LEFT,
        ST_RIGHT
    } state_t;

    state_t                   r_state;
    logic                     r_ws_q;
    logic [CW-1:0]            r_cnt;
    logic [WORD_LENGTH-1:0]   r_sh;
    logic [WORD_LENGTH-1:0]   r_left_hold;
    logic [2*WORD_LENGTH-1:0] r_data;
    logic                     r_data_valid;

    state_t                   w_state_next;
    logic [CW-1:0]            w_cnt_next;
    logic [WORD_LENGTH-1:0]   w_sh_next;
    logic [WORD_LENGTH-1:0]   w_left_next;
    logic [WORD_LENGTH-1:0]   w_sh_shift;
    logic                     w_fall;
    logic                     w_rise;
    logic                     w_edge;
    logic                     w_complete;
    logic                     w_load;

    assign w_fall     = r_ws_q & ~bus.word_select;
    assign w_rise     = ~r_ws_q & bus.word_select;
    assign w_edge     = w_fall | w_rise;
    assign w_sh_shift = {r_sh[WORD_LENGTH-2:0], bus.serial_data};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_SYNC;
            r_ws_q      <= 1'b0;
            r_cnt       <= '0;
            r_sh        <= '0;
            r_left_hold <= '0;
        end else begin
            r_state     <= w_state_next;
            r_ws_q      <= bus.word_select;
            r_cnt       <= w_cnt_next;
            r_sh        <= w_sh_next;
            r_left_hold <= w_left_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_sh_next    = r_sh;
        w_left_next  = r_left_hold;
        w_complete   = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (w_fall) begin
                    w_state_next = ST_LEFT;
                    w_cnt_next   = '0;
                end
            end
            ST_LEFT: begin
                if (w_edge) begin
                    w_cnt_next = '0;
                    // Short word: fall restarts the left word, rise loses sync.
                    if (r_cnt < LP_LAST) begin
                        w_state_next = w_fall ? ST_LEFT : ST_SYNC;
                    end else if (w_rise) begin
                        if (r_cnt == LP_LAST) begin
                            w_sh_next   = w_sh_shift;
                            w_left_next = w_sh_shift;
                        end
                        w_state_next = ST_RIGHT;
                    end else begin
                        w_state_next = ST_LEFT;
                    end
                end else if (r_cnt < LP_FULL) begin
                    w_sh_next  = w_sh_shift;
                    w_cnt_next = r_cnt + CW'(1);
                    if (r_cnt == LP_LAST) begin
                        w_left_next = w_sh_shift;
                    end
                end
            end
            ST_RIGHT: begin
                if (w_edge) begin
                    w_cnt_next = '0;
                    if (r_cnt < LP_LAST) begin
                        w_state_next = w_fall ? ST_LEFT : ST_SYNC;
                    end else if (w_fall) begin
                        if (r_cnt == LP_LAST) begin
                            w_sh_next  = w_sh_shift;
                            w_complete = 1'b1;
                        end
                        w_state_next = ST_LEFT;
                    end else begin
                        w_state_next = ST_SYNC;
                    end
                end else if (r_cnt < LP_FULL) begin
                    // Right word completes on its own count; the line may idle high.
                    w_sh_next  = w_sh_shift;
                    w_cnt_next = r_cnt + CW'(1);
                    if (r_cnt == LP_LAST) begin
                        w_complete = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_SYNC;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign w_load = w_complete & (~r_data_valid | bus.data_ready);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data       <= '0;
            r_data_valid <= 1'b0;
        end else if (w_load) begin
            r_data       <= {r_left_hold, w_sh_next};
            r_data_valid <= 1'b1;
        end else if (bus.data_ready) begin
            r_data_valid <= 1'b0;
        end
    end

    assign bus.data       = r_data;
    assign bus.data_valid = r_data_valid;

`ifdef I2S_RECEIVER_ERROR_FLAGS_EN
    logic r_overrun;
    logic r_frame_error;
    logic w_short;
    logic w_drop;

    assign w_short = (r_state != ST_SYNC) & w_edge & (r_cnt < LP_LAST);
    assign w_drop  = w_complete & r_data_valid & ~bus.data_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overrun     <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
            if (w_short) begin
                r_frame_error <= 1'b1;
            end
        end
    end

    assign bus.overrun     = r_overrun;
    assign bus.frame_error = r_frame_error;
`else
    assign bus.overrun     = 1'b0;
    assign bus.frame_error = 1'b0;
`endif
endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver (WORD_LENGTH=16): drives I2S slots on the falling edge,
// logs accepted frames at the rising edge and compares against hand-computed values.
module tb_i2s_receiver;
    localparam int WL = 16;
`ifdef I2S_RECEIVER_ERROR_FLAGS_EN
    localparam logic FLAGS = 1'b1;
`else
    localparam logic FLAGS = 1'b0;
`endif

    logic clk;
    logic rst;
    logic prev_lsb;
    int   n_checks;
    int   n_errors;
    int   cyc;
    logic [31:0] q_data[$];
    int          q_cyc[$];

    i2s_receiver_if #(.WORD_LENGTH(WL)) bus ();

    i2s_receiver #(.WORD_LENGTH(WL)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        cyc++;
        if (!rst && bus.data_valid && bus.data_ready) begin
            q_data.push_back(bus.data);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic slot(input logic ws, input logic sd);
        @(negedge clk);
        bus.word_select = ws;
        bus.serial_data = sd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) slot(1'b1, 1'b0);
    endtask

    // Sends up to n slots of one frame; slot 0 carries the previous right LSB.
    task automatic send_frame(input logic [31:0] f, input int n);
        logic [15:0] l;
        logic [15:0] r;
        l = f[31:16];
        r = f[15:0];
        for (int k = 0; k < 32 && k < n; k++) begin
            if (k < 16) slot(1'b0, (k == 0) ? prev_lsb : l[16-k]);
            else        slot(1'b1, (k == 16) ? l[0] : r[32-k]);
        end
        prev_lsb = r[0];
    endtask

    task automatic tail();
        slot(1'b1, prev_lsb);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        prev_lsb = 1'b0;
        rst      = 1'b1;
        bus.word_select = 1'b0;
        bus.serial_data = 1'b0;
        bus.data_ready  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_data",  bus.data, 0);
        check_eq("rst_valid", bus.data_valid, 0);
        check_eq("rst_ovr",   bus.overrun, 0);
        check_eq("rst_ferr",  bus.frame_error, 0);

        // Basic frame with exact latency
        idle(2);
        send_frame(32'hA5A53C3C, 32);
        @(posedge clk); #1;
        check_eq("basic_pre_valid", bus.data_valid, 0);
        tail();
        @(posedge clk); #1;
        check_eq("basic_valid", bus.data_valid, 1);
        check_eq("basic_data",  bus.data, 64'hA5A53C3C);
        idle(2);
        check_eq("basic_count", q_data.size(), 1);
        q_data.delete();
        q_cyc.delete();

        // Back-to-back streaming
        send_frame(32'h00010002, 32);
        send_frame(32'hFFFF8000, 32);
        send_frame(32'h12345678, 32);
        tail();
        idle(3);
        check_eq("stream_count", q_data.size(), 3);
        if (q_data.size() == 3) begin
            check_eq("stream_f0", q_data[0], 64'h00010002);
            check_eq("stream_f1", q_data[1], 64'hFFFF8000);
            check_eq("stream_f2", q_data[2], 64'h12345678);
            check_eq("stream_gap01", q_cyc[1] - q_cyc[0], 32);
            check_eq("stream_gap12", q_cyc[2] - q_cyc[1], 32);
        end
        q_data.delete();
        q_cyc.delete();

        // Simultaneous accept and complete
        bus.data_ready = 1'b0;
        send_frame(32'hDEAD0001, 32);
        send_frame(32'h0BEE0002, 32);
        tail();
        bus.data_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("simul_valid", bus.data_valid, 1);
        check_eq("simul_data",  bus.data, 64'h0BEE0002);
        check_eq("simul_ovr",   bus.overrun, 0);
        idle(2);
        check_eq("simul_count", q_data.size(), 2);
        if (q_data.size() == 2) begin
            check_eq("simul_f0", q_data[0], 64'hDEAD0001);
            check_eq("simul_f1", q_data[1], 64'h0BEE0002);
        end
        q_data.delete();
        q_cyc.delete();

        // Overrun
        bus.data_ready = 1'b0;
        send_frame(32'h11112222, 32);
        send_frame(32'h33334444, 32);
        tail();
        idle(2);
        @(posedge clk); #1;
        check_eq("ovr_valid", bus.data_valid, 1);
        check_eq("ovr_data",  bus.data, 64'h11112222);
        check_eq("ovr_flag",  bus.overrun, FLAGS);
        check_eq("ovr_none_taken", q_data.size(), 0);
        slot(1'b1, 1'b0);
        bus.data_ready = 1'b1;
        slot(1'b1, 1'b0);
        check_eq("ovr_drain_valid", bus.data_valid, 0);
        check_eq("ovr_drain_count", q_data.size(), 1);
        if (q_data.size() == 1) check_eq("ovr_drain_data", q_data[0], 64'h11112222);
        q_data.delete();
        q_cyc.delete();

        // Short word: rise after 10 left bits
        slot(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) slot(1'b0, 1'(i % 2));
        slot(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) slot(1'b1, 1'b1);
        @(posedge clk); #1;
        check_eq("short_valid", bus.data_valid, 0);
        check_eq("short_ferr",  bus.frame_error, FLAGS);
        check_eq("short_none",  q_data.size(), 0);
        prev_lsb = 1'b1;
        send_frame(32'hCAFEBABE, 32);
        tail();
        idle(2);
        check_eq("short_next_count", q_data.size(), 1);
        if (q_data.size() == 1) check_eq("short_next_data", q_data[0], 64'hCAFEBABE);
        q_data.delete();
        q_cyc.delete();

        // Reset after 8 right-word bits
        send_frame(32'h5A5A9999, 25);
        slot(1'b1, 1'b1);
        rst = 1'b1;
        slot(1'b1, 1'b0);
        rst = 1'b0;
        check_eq("mrst_data",  bus.data, 0);
        check_eq("mrst_valid", bus.data_valid, 0);
        check_eq("mrst_ovr",   bus.overrun, 0);
        check_eq("mrst_ferr",  bus.frame_error, 0);
        idle(8);
        check_eq("mrst_none", q_data.size(), 0);
        send_frame(32'h0F0FF0F0, 32);
        tail();
        idle(2);
        check_eq("mrst_next_count", q_data.size(), 1);
        if (q_data.size() == 1) check_eq("mrst_next_data", q_data[0], 64'h0F0FF0F0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
